// File: rtl/pix_window_2x2.sv
// 2x2 sliding-window generator over a raster pixel stream, buffering one previous line.
module pix_window_2x2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned CW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             sof,
  input  logic [WIDTH-1:0] dinput,
  output logic             win_valid,
  output logic [WIDTH-1:0] p00,
  output logic [WIDTH-1:0] p01,
  output logic [WIDTH-1:0] p10,
  output logic [WIDTH-1:0] p11,
  output logic [CW-1:0]    row_out,
  output logic [CW-1:0]    col_out
);

  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  // Previous-line storage; never reset because row 0 emits no windows.
  logic [WIDTH-1:0] linebuf_q [IMG_W];

  logic [CW-1:0]    col_q, col_d, row_q, row_d;
  logic [CW-1:0]    cur_col_c, cur_row_c;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_pix_q, s1_pix_d;
  logic [WIDTH-1:0] s1_top_q, s1_top_d;
  logic [CW-1:0]    s1_col_q, s1_col_d, s1_row_q, s1_row_d;

  logic [WIDTH-1:0] top_cur_q, top_cur_d, bot_cur_q, bot_cur_d;

  logic             win_valid_q, win_valid_d;
  logic [WIDTH-1:0] p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
  logic [CW-1:0]    row_out_q, row_out_d, col_out_q, col_out_d;

  // Coordinate of the pixel offered this cycle and the next expected coordinate.
  always_comb begin
    cur_col_c = sof ? '0 : col_q;
    cur_row_c = sof ? '0 : row_q;
    col_d     = col_q;
    row_d     = row_q;
    if (din_valid) begin
      if (cur_col_c == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row_c == CW'(IMG_H - 1)) ? '0 : cur_row_c + CW'(1);
      end else begin
        col_d = cur_col_c + CW'(1);
        row_d = cur_row_c;
      end
    end
  end

  // Stage 1: capture pixel, coordinates and the pixel directly above (read before write).
  always_comb begin
    s1_valid_d = din_valid;
    s1_pix_d   = s1_pix_q;
    s1_top_d   = s1_top_q;
    s1_col_d   = s1_col_q;
    s1_row_d   = s1_row_q;
    if (din_valid) begin
      s1_pix_d = dinput;
      s1_top_d = linebuf_q[AW'(cur_col_c)];
      s1_col_d = cur_col_c;
      s1_row_d = cur_row_c;
    end
  end

  // Stage 2: shift the column pair and register the window when it is complete.
  always_comb begin
    top_cur_d   = top_cur_q;
    bot_cur_d   = bot_cur_q;
    win_valid_d = s1_valid_q && (s1_row_q != '0) && (s1_col_q != '0);
    p00_d       = p00_q;
    p01_d       = p01_q;
    p10_d       = p10_q;
    p11_d       = p11_q;
    row_out_d   = row_out_q;
    col_out_d   = col_out_q;
    if (s1_valid_q) begin
      top_cur_d = s1_top_q;
      bot_cur_d = s1_pix_q;
    end
    if (win_valid_d) begin
      p00_d     = top_cur_q;
      p01_d     = s1_top_q;
      p10_d     = bot_cur_q;
      p11_d     = s1_pix_q;
      row_out_d = s1_row_q;
      col_out_d = s1_col_q;
    end
  end

  // Line buffer write; a pixel presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (din_valid && !rst) begin
      linebuf_q[AW'(cur_col_c)] <= dinput;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_top_q    <= '0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      top_cur_q   <= '0;
      bot_cur_q   <= '0;
      win_valid_q <= 1'b0;
      p00_q       <= '0;
      p01_q       <= '0;
      p10_q       <= '0;
      p11_q       <= '0;
      row_out_q   <= '0;
      col_out_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      s1_valid_q  <= s1_valid_d;
      s1_pix_q    <= s1_pix_d;
      s1_top_q    <= s1_top_d;
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      top_cur_q   <= top_cur_d;
      bot_cur_q   <= bot_cur_d;
      win_valid_q <= win_valid_d;
      p00_q       <= p00_d;
      p01_q       <= p01_d;
      p10_q       <= p10_d;
      p11_q       <= p11_d;
      row_out_q   <= row_out_d;
      col_out_q   <= col_out_d;
    end
  end

  assign win_valid = win_valid_q;
  assign p00       = p00_q;
  assign p01       = p01_q;
  assign p10       = p10_q;
  assign p11       = p11_q;
  assign row_out   = row_out_q;
  assign col_out   = col_out_q;

endmodule

// File: tb/tb_pix_window_2x2.sv
// Self-checking bench for pix_window_2x2 using a whole-image reference model.
module tb_pix_window_2x2;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned IH = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned OW = 1 + 4 * W + 2 * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic          sof = 1'b0;
  logic [W-1:0]  dinput = '0;
  logic          win_valid;
  logic [W-1:0]  p00, p01, p10, p11;
  logic [CW-1:0] row_out, col_out;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: full image store plus expected output state.
  logic [W-1:0]  img [IH][IW];
  int            mr = 0, mc = 0;
  logic          m1_v = 1'b0;
  logic [OW-1:0] m1_vec = '0;
  logic [OW-1:0] exp_vec = '0;
  logic [OW-1:0] win_log [$];

  pix_window_2x2 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .sof(sof), .dinput(dinput),
    .win_valid(win_valid), .p00(p00), .p01(p01), .p10(p10), .p11(p11),
    .row_out(row_out), .col_out(col_out)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pack(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d, input int r, input int k);
    return {v, a, b, c, d, CW'(r), CW'(k)};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {win_valid, p00, p01, p10, p11, row_out, col_out};
  endfunction

  // Drive one cycle, advance the model across the clock edge, return at the following negedge.
  task automatic cyc(input logic v, input logic s, input logic [W-1:0] d, input logic r);
    int rr, cc;
    din_valid = v; sof = s; dinput = d; rst = r;
    @(posedge clk);
    if (r) begin
      exp_vec = '0; m1_v = 1'b0; mr = 0; mc = 0;
    end else begin
      if (m1_v && m1_vec[OW-1]) exp_vec = m1_vec;
      else exp_vec[OW-1] = 1'b0;
      m1_v = v;
      if (v) begin
        rr = s ? 0 : mr;
        cc = s ? 0 : mc;
        img[rr][cc] = d;
        if (rr >= 1 && cc >= 1)
          m1_vec = pack(1'b1, img[rr-1][cc-1], img[rr-1][cc], img[rr][cc-1], d, rr, cc);
        else
          m1_vec = '0;
        cc++;
        if (cc == IW) begin
          cc = 0; rr++;
          if (rr == IH) rr = 0;
        end
        mr = rr; mc = cc;
      end
    end
    @(negedge clk);
    if (win_valid) win_log.push_back(obs());
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_chk++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL reset_state: got %h want %h", obs(), {OW{1'b0}});
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_chk++;
    if (obs() !== exp_vec) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", obs(), exp_vec);
    end
  endtask

  task automatic test_continuous();
    win_log.delete();
    for (int k = 0; k < 12 + 3; k++) begin
      if (k < 12) cyc(1'b1, k == 0, W'((k / 4) * 16 + (k % 4)), 1'b0);
      else cyc(1'b0, 1'b0, '0, 1'b0);
      n_chk++;
      if (obs() !== exp_vec) begin
        n_err++; $display("FAIL cont_cyc%0d: got %h want %h", k, obs(), exp_vec);
      end
    end
    n_chk++;
    if (win_log.size() != 6) begin
      n_err++; $display("FAIL cont_count: got %0d want 6", win_log.size());
    end else begin
      n_chk++;
      if (win_log[0] !== pack(1'b1, 8'h00, 8'h01, 8'h10, 8'h11, 1, 1)) begin
        n_err++; $display("FAIL cont_first: got %h want %h", win_log[0], pack(1'b1, 8'h00, 8'h01, 8'h10, 8'h11, 1, 1));
      end
      n_chk++;
      if (win_log[5] !== pack(1'b1, 8'h12, 8'h13, 8'h22, 8'h23, 2, 3)) begin
        n_err++; $display("FAIL cont_last: got %h want %h", win_log[5], pack(1'b1, 8'h12, 8'h13, 8'h22, 8'h23, 2, 3));
      end
    end
  endtask

  task automatic test_gapped();
    win_log.delete();
    for (int k = 0; k < 24 + 4; k++) begin
      if (k < 24 && k % 2 == 0) cyc(1'b1, k == 0, W'((k / 8) * 16 + ((k / 2) % 4)), 1'b0);
      else cyc(1'b0, 1'b0, W'($urandom), 1'b0);
      n_chk++;
      if (obs() !== exp_vec) begin
        n_err++; $display("FAIL gap_cyc%0d: got %h want %h", k, obs(), exp_vec);
      end
    end
    n_chk++;
    if (win_log.size() != 6 || win_log[0] !== pack(1'b1, 8'h00, 8'h01, 8'h10, 8'h11, 1, 1)
        || win_log[5] !== pack(1'b1, 8'h12, 8'h13, 8'h22, 8'h23, 2, 3)) begin
      n_err++; $display("FAIL gap_windows: got count %0d want 6 with first/last as continuous", win_log.size());
    end
  endtask

  task automatic test_line_boundary();
    win_log.delete();
    for (int k = 0; k < 12 + 3; k++) begin
      if (k < 12) cyc(1'b1, k == 0, W'((k / 4) * 16 + (k % 4)), 1'b0);
      else cyc(1'b0, 1'b0, '0, 1'b0);
      n_chk++;
      if (obs() !== exp_vec) begin
        n_err++; $display("FAIL lb_cyc%0d: got %h want %h", k, obs(), exp_vec);
      end
    end
    foreach (win_log[i]) begin
      n_chk++;
      if (win_log[i][2*CW-1:CW] == '0 || win_log[i][CW-1:0] == '0) begin
        n_err++; $display("FAIL lb_zero_coord: got row/col %h want nonzero", win_log[i][2*CW-1:0]);
      end
    end
    n_chk++;
    if (win_log.size() < 4 || win_log[3] !== pack(1'b1, 8'h10, 8'h11, 8'h20, 8'h21, 2, 1)) begin
      n_err++; $display("FAIL lb_win21: got %h want %h", (win_log.size() < 4) ? '0 : win_log[3],
                        pack(1'b1, 8'h10, 8'h11, 8'h20, 8'h21, 2, 1));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] f2 [12];
    win_log.delete();
    for (int k = 0; k < 12; k++) f2[k] = W'($urandom);
    for (int k = 0; k < 24 + 3; k++) begin
      if (k < 12) cyc(1'b1, k == 0, W'($urandom), 1'b0);
      else if (k < 24) cyc(1'b1, k == 12, f2[k-12], 1'b0);
      else cyc(1'b0, 1'b0, '0, 1'b0);
      n_chk++;
      if (obs() !== exp_vec) begin
        n_err++; $display("FAIL b2b_cyc%0d: got %h want %h", k, obs(), exp_vec);
      end
    end
    n_chk++;
    if (win_log.size() != 12 || win_log[6] !== pack(1'b1, f2[0], f2[1], f2[4], f2[5], 1, 1)) begin
      n_err++; $display("FAIL b2b_frame2: got count %0d win %h want 12 and %h", win_log.size(),
                        (win_log.size() > 6) ? win_log[6] : '0, pack(1'b1, f2[0], f2[1], f2[4], f2[5], 1, 1));
    end
  endtask

  task automatic test_mid_sof();
    int base;
    win_log.delete();
    for (int k = 0; k < 6 + 12 + 3; k++) begin
      if (k < 6) cyc(1'b1, k == 0, W'((k / 4) * 16 + (k % 4)), 1'b0);
      else if (k < 18) cyc(1'b1, k == 6, W'(8'h80 + ((k - 6) / 4) * 16 + ((k - 6) % 4)), 1'b0);
      else cyc(1'b0, 1'b0, '0, 1'b0);
      if (k == 7) base = win_log.size();
      if (k == 11) begin
        n_chk++;
        if (win_log.size() != base) begin
          n_err++; $display("FAIL sof_row0_windows: got %0d want 0", win_log.size() - base);
        end
      end
      n_chk++;
      if (obs() !== exp_vec) begin
        n_err++; $display("FAIL sof_cyc%0d: got %h want %h", k, obs(), exp_vec);
      end
    end
    n_chk++;
    if (win_log.size() != 7 || win_log[1] !== pack(1'b1, 8'h80, 8'h81, 8'h90, 8'h91, 1, 1)) begin
      n_err++; $display("FAIL sof_new11: got count %0d win %h want 7 and %h", win_log.size(),
                        (win_log.size() > 1) ? win_log[1] : '0, pack(1'b1, 8'h80, 8'h81, 8'h90, 8'h91, 1, 1));
    end
  endtask

  task automatic test_rst_inflight();
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, k == 0, W'((k / 4) * 16 + (k % 4)), 1'b0);
      n_chk++;
      if (obs() !== exp_vec) begin
        n_err++; $display("FAIL rsti_cyc%0d: got %h want %h", k, obs(), exp_vec);
      end
    end
    cyc(1'b1, 1'b0, 8'hAA, 1'b1);
    n_chk++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL rsti_cleared: got %h want %h", obs(), {OW{1'b0}});
    end
    win_log.delete();
    for (int k = 0; k < 12 + 3; k++) begin
      if (k < 12) cyc(1'b1, 1'b0, W'(8'h40 + (k / 4) * 16 + (k % 4)), 1'b0);
      else cyc(1'b0, 1'b0, '0, 1'b0);
      n_chk++;
      if (obs() !== exp_vec) begin
        n_err++; $display("FAIL rsti_post%0d: got %h want %h", k, obs(), exp_vec);
      end
    end
    n_chk++;
    if (win_log.size() != 6 || win_log[0] !== pack(1'b1, 8'h40, 8'h41, 8'h50, 8'h51, 1, 1)) begin
      n_err++; $display("FAIL rsti_restart: got count %0d win %h want 6 and %h", win_log.size(),
                        (win_log.size() > 0) ? win_log[0] : '0, pack(1'b1, 8'h40, 8'h41, 8'h50, 8'h51, 1, 1));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      cyc(($urandom % 3) != 0, k == 0 || ($urandom % 40) == 0, W'($urandom), 1'b0);
      n_chk++;
      if (obs() !== exp_vec) begin
        n_err++; $display("FAIL rand_cyc%0d: got %h want %h", k, obs(), exp_vec);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_continuous();
    test_gapped();
    test_line_boundary();
    test_back_to_back();
    test_mid_sof();
    test_rst_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
